// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and single-cycle access sequencer for the byte-addressed data memory.
// Define DMEM_ARB_ALIGN_CHECK_EN to reject misaligned or out-of-range word accesses with err.
module dmem_arbiter #(
  parameter int unsigned DEPTH_BYTES = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic        i_we0,
  input  logic        i_we1,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  output logic        o_gnt0,
  output logic        o_gnt1,
  output logic        o_rvalid0,
  output logic        o_rvalid1,
  output logic [31:0] o_rdata0,
  output logic [31:0] o_rdata1,
  output logic        o_err0,
  output logic        o_err1,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_write_data,
  output logic        o_mem_read_enable,
  output logic        o_mem_write_enable,
  input  logic [31:0] i_mem_read_data
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      r_state, w_state_d;
  logic        r_prio, r_owner, r_we;
  logic [31:0] r_addr, r_wdata, r_rdata0, r_rdata1;
  logic        w_access, w_resp, w_arb, w_winner, w_reject;
  logic [31:0] w_rdata_cap;

  if (DEPTH_BYTES < 4 || DEPTH_BYTES % 4 != 0) begin : g_bad_depth
    $error("DEPTH_BYTES must be a non-zero multiple of 4");
  end

  assign w_access = (r_state == StAccess);
  assign w_resp   = (r_state == StResp);
  assign w_arb    = (r_state != StAccess) && (i_req0 || i_req1);
  // A lone request wins outright; contention is settled by the round-robin pointer.
  assign w_winner = (i_req0 && i_req1) ? r_prio : i_req1;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic r_err;

  assign w_reject = (r_addr[1:0] != 2'b00) || (r_addr > 32'(DEPTH_BYTES - 4));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (w_access) begin
      r_err <= w_reject;
    end
  end

  assign o_err0 = w_resp && !r_owner && r_err;
  assign o_err1 = w_resp &&  r_owner && r_err;
`else
  assign w_reject = 1'b0;
  assign o_err0   = 1'b0;
  assign o_err1   = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle, StResp: w_state_d = (i_req0 || i_req1) ? StAccess : StIdle;
      StAccess:       w_state_d = StResp;
      default:        w_state_d = StIdle;
    endcase
  end

  assign w_rdata_cap = (r_we || w_reject) ? 32'd0 : i_mem_read_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_prio   <= 1'b0;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_arb) begin
        r_owner <= w_winner;
        r_we    <= w_winner ? i_we1 : i_we0;
        r_addr  <= w_winner ? i_addr1 : i_addr0;
        r_wdata <= w_winner ? i_wdata1 : i_wdata0;
      end
      if (w_access) begin
        r_prio <= ~r_owner;
        // Only the owner's response register moves, so rdataN changes together with rvalidN.
        if (r_owner) begin
          r_rdata1 <= w_rdata_cap;
        end else begin
          r_rdata0 <= w_rdata_cap;
        end
      end
    end
  end

  assign o_gnt0             = w_access && !r_owner;
  assign o_gnt1             = w_access &&  r_owner;
  assign o_rvalid0          = w_resp && !r_owner;
  assign o_rvalid1          = w_resp &&  r_owner;
  assign o_rdata0           = r_rdata0;
  assign o_rdata1           = r_rdata1;
  assign o_mem_address      = r_addr;
  assign o_mem_write_data   = r_wdata;
  assign o_mem_write_enable = w_access &&  r_we && !w_reject;
  assign o_mem_read_enable  = w_access && !r_we && !w_reject;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios and random two-port traffic against a cycle-level
// transaction model and a byte-array shadow of the data memory.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  typedef struct packed {
    logic        t_we;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
  } txn_t;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, we;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1, mem_address, mem_write_data, mem_read_data;
  logic        mem_read_enable, mem_write_enable;

  logic [7:0]  mem [32];
  logic [7:0]  ref_mem [32];
  logic        mem_fill;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc, last_gnt, last_owner;
  logic [31:0] exp_rdata, exp_addr, exp_wdata, last_rdata0;
  logic        exp_err, exp_wr;
  logic [1:0]  pend;
  txn_t        q0[$], q1[$];

  dmem_arbiter #(.DEPTH_BYTES(32)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_req0             (req[0]),
    .i_req1             (req[1]),
    .i_we0              (we[0]),
    .i_we1              (we[1]),
    .i_addr0            (addr[0]),
    .i_addr1            (addr[1]),
    .i_wdata0           (wdata[0]),
    .i_wdata1           (wdata[1]),
    .o_gnt0             (gnt0),
    .o_gnt1             (gnt1),
    .o_rvalid0          (rvalid0),
    .o_rvalid1          (rvalid1),
    .o_rdata0           (rdata0),
    .o_rdata1           (rdata1),
    .o_err0             (err0),
    .o_err1             (err1),
    .o_mem_address      (mem_address),
    .o_mem_write_data   (mem_write_data),
    .o_mem_read_enable  (mem_read_enable),
    .o_mem_write_enable (mem_write_enable),
    .i_mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;

  // 32-byte little-endian memory; bytes past the end read as 0 and ignore writes.
  always_comb begin
    mem_read_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (mem_address + 32'(i) < 32'd32) mem_read_data[8*i +: 8] = mem[5'(mem_address + 32'(i))];
    end
  end

  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 32; i++) mem[i] <= ref_mem[i];
    end else if (mem_write_enable) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_address + 32'(i) < 32'd32)
          mem[5'(mem_address + 32'(i))] <= mem_write_data[8*i +: 8];
      end
    end
  end

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) begin
      if (a + 32'(i) < 32'd32) w[8*i +: 8] = ref_mem[5'(a + 32'(i))];
    end
    return w;
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      if (a + 32'(i) < 32'd32) ref_mem[5'(a + 32'(i))] = d[8*i +: 8];
    end
  endfunction

  function automatic logic ref_err(input logic [31:0] a);
    return ALIGN_CHECK && ((a[1:0] != 2'b00) || (a > 32'd28));
  endfunction

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.t_we    = w;
    t.t_addr  = a;
    t.t_wdata = d;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    logic [31:0] a;
    a = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 39)) : 32'(4 * $urandom_range(0, 7));
    return mk(1'($urandom_range(0, 1)), a, $urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic reset_checks();
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    chk("rst_err0", 32'(err0), 32'd0);
    chk("rst_err1", 32'(err1), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_write_data", mem_write_data, 32'd0);
    chk("rst_mem_read_enable", 32'(mem_read_enable), 32'd0);
    chk("rst_mem_write_enable", 32'(mem_write_enable), 32'd0);
  endtask

  // One clock cycle: check this cycle's outputs against the model, then drive the next requests.
  task automatic step();
    logic        rv, any, win, w_we, w_err;
    logic [31:0] w_addr;
    txn_t        t;
    @(negedge clk);
    cyc++;
    rv = (cyc == last_gnt + 1);
    chk("rvalid0", 32'(rvalid0), 32'(rv && last_owner == 0));
    chk("rvalid1", 32'(rvalid1), 32'(rv && last_owner == 1));
    if (rv) begin
      chk("rdata", (last_owner == 1) ? rdata1 : rdata0, exp_rdata);
      chk("err", 32'((last_owner == 1) ? err1 : err0), 32'(exp_err));
      if (last_owner == 0) last_rdata0 = rdata0;
      if (exp_wr) ref_write(exp_addr, exp_wdata);
    end
    // A grant this cycle needs a request at the opening edge while the port was not busy.
    any    = (req != 2'b00) && (cyc - 1 != last_gnt);
    win    = (req == 2'b11) ? (last_owner == 0) : req[1];
    w_we   = we[win];
    w_addr = addr[win];
    w_err  = ref_err(w_addr);
    chk("gnt0", 32'(gnt0), 32'(any && !win));
    chk("gnt1", 32'(gnt1), 32'(any && win));
    chk("mem_write_enable", 32'(mem_write_enable), 32'(any && w_we && !w_err));
    chk("mem_read_enable", 32'(mem_read_enable), 32'(any && !w_we && !w_err));
    if (any) begin
      chk("mem_address", mem_address, w_addr);
      if (w_we) chk("mem_write_data", mem_write_data, wdata[win]);
      exp_rdata  = (w_we || w_err) ? 32'd0 : ref_read(w_addr);
      exp_err    = w_err;
      exp_wr     = w_we && !w_err;
      exp_addr   = w_addr;
      exp_wdata  = wdata[win];
      last_gnt   = cyc;
      last_owner = int'(win);
    end
    for (int p = 0; p < 2; p++) begin
      if ((p == 0 && gnt0) || (p == 1 && gnt1)) begin
        pend[p] = 1'b0;
        req[p]  = 1'b0;
      end
      if (!pend[p]) begin
        if (p == 0 && q0.size() != 0) t = q0.pop_front();
        else if (p == 1 && q1.size() != 0) t = q1.pop_front();
        else continue;
        req[p]   = 1'b1;
        we[p]    = t.t_we;
        addr[p]  = t.t_addr;
        wdata[p] = t.t_wdata;
        pend[p]  = 1'b1;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || pend != 2'b00 || cyc <= last_gnt + 1)
           && n < budget) begin
      step();
      n++;
    end
    chk("drain_left", 32'(q0.size() + q1.size()) + 32'(pend), 32'd0);
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    req         = '0;
    we          = '0;
    addr[0]     = '0;
    addr[1]     = '0;
    wdata[0]    = '0;
    wdata[1]    = '0;
    pend        = '0;
    mem_fill    = 1'b1;
    cyc         = 0;
    last_gnt    = -10;
    last_owner  = 1;
    exp_rdata   = '0;
    exp_addr    = '0;
    exp_wdata   = '0;
    exp_err     = 1'b0;
    exp_wr      = 1'b0;
    last_rdata0 = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'($urandom);
    @(negedge clk);
    @(negedge clk);
    mem_fill = 1'b0;
    reset_checks();
    rst_n = 1'b1;

    // Simultaneous requests straight out of reset: port 0 first, then port 1.
    q0.push_back(mk(1'b0, 32'h0, 32'h0));
    q1.push_back(mk(1'b0, 32'h10, 32'h0));
    drain(40);

    // Write then read back on port 0.
    q0.push_back(mk(1'b1, 32'h4, 32'hDEADBEEF));
    q0.push_back(mk(1'b0, 32'h4, 32'h0));
    drain(40);
    chk("write_read_back", last_rdata0, 32'hDEADBEEF);

    // Both ports keep requesting: grants must alternate, one every two cycles.
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(1'b0, 32'(8 * i), 32'h0));
      q1.push_back(mk(1'b1, 32'(8 * i + 4), $urandom));
    end
    drain(60);

    // Reset during the ACCESS cycle of a write: strobe drops at once, nothing lands.
    q0.push_back(mk(1'b1, 32'h8, 32'h12345678));
    n = 0;
    do begin
      step();
      n++;
    end while (!gnt0 && n < 10);
    chk("rst_mid_gnt_seen", 32'(gnt0), 32'd1);
    rst_n = 1'b0;
    req   = '0;
    pend  = '0;
    q0.delete();
    q1.delete();
    #1;
    chk("rst_mid_write_enable", 32'(mem_write_enable), 32'd0);
    chk("rst_mid_gnt0", 32'(gnt0), 32'd0);
    last_gnt   = -10;
    last_owner = 1;
    @(negedge clk);
    @(negedge clk);
    reset_checks();
    rst_n = 1'b1;
    chk("rst_mid_no_write", 32'(mem_diff()), 32'd0);
    q0.push_back(mk(1'b0, 32'h8, 32'h0));
    drain(20);
    chk("rst_mid_read_back", last_rdata0, ref_read(32'h8));

    // Unaligned read passes straight through unless alignment checking is built in.
    q0.push_back(mk(1'b0, 32'h2, 32'h0));
    drain(20);
    chk("unaligned_read", last_rdata0,
        ALIGN_CHECK ? 32'd0 : {ref_mem[5], ref_mem[4], ref_mem[3], ref_mem[2]});

    // Rejected writes (misaligned, past the end) and the last legal word.
    q1.push_back(mk(1'b1, 32'h6, $urandom));
    q1.push_back(mk(1'b1, 32'h20, $urandom));
    q1.push_back(mk(1'b0, 32'h1C, 32'h0));
    q1.push_back(mk(1'b1, 32'h1C, $urandom));
    q1.push_back(mk(1'b0, 32'h1C, 32'h0));
    drain(40);
    chk("edge_mem_contents", 32'(mem_diff()), 32'd0);

    for (int i = 0; i < 400; i++) begin
      if (q0.size() == 0 && $urandom_range(0, 3) != 0) q0.push_back(rnd_txn());
      if (q1.size() == 0 && $urandom_range(0, 3) != 0) q1.push_back(rnd_txn());
      step();
    end
    drain(40);
    chk("final_mem_contents", 32'(mem_diff()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
